// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the shared floating-point multiplier arbiter.
package fp_mul_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int EXC_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Request/response bundle between the floating-point clients (master) and fp_mul_arbiter (slave).
interface fp_mul_arbiter_if
  import fp_mul_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_W       = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_m;
  logic                          rsp_overflow;
  logic                          rsp_underflow;
  logic [EXC_CNT_W-1:0]          exc_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_m, rsp_overflow, rsp_underflow, exc_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_m, rsp_overflow, rsp_underflow, exc_count
  );

endinterface

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, searched cyclically.
module fp_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  logic [ID_W-1:0] cand_s;

  // Cyclic priority search starting at the round-robin pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand_s    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any_valid && req[cand_s]) begin
        any_valid     = 1'b1;
        grant_idx     = cand_s;
        grant[cand_s] = 1'b1;
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/mul_main.sv
// Combinational IEEE-754 single multiplier: round-to-nearest-even, zero/denormal inputs
// flush to signed zero, overflow saturates to infinity, underflow flushes to zero.
module mul_main (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] m,
  output logic        overflow,
  output logic        underflow
);

  logic               sign_s;
  logic [47:0]        prod_s;
  logic [47:0]        norm_s;
  logic               round_up_s;
  logic [24:0]        sig_r_s;
  logic [22:0]        frac_s;
  logic signed [9:0]  exp_s;

  // Significand product, normalisation, rounding and exception classification.
  always_comb begin
    sign_s     = a[31] ^ b[31];
    prod_s     = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    norm_s     = prod_s[47] ? prod_s : (prod_s << 1);
    round_up_s = norm_s[23] & ((|norm_s[22:0]) | norm_s[24]);
    sig_r_s    = {1'b0, norm_s[47:24]} + {24'd0, round_up_s};
    frac_s     = sig_r_s[24] ? sig_r_s[23:1] : sig_r_s[22:0];
    exp_s      = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
               + $signed({9'd0, prod_s[47]}) + $signed({9'd0, sig_r_s[24]});
    m          = 32'd0;
    overflow   = 1'b0;
    underflow  = 1'b0;
    if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) begin
      m = {sign_s, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      m        = {sign_s, 8'hFF, 23'd0};
      overflow = 1'b1;
    end else if (exp_s <= 10'sd0) begin
      m         = {sign_s, 31'd0};
      underflow = 1'b1;
    end else begin
      m = {sign_s, exp_s[7:0], frac_s};
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one mul_main among NUM_REQ valid/ready requesters with a registered
// response port. Define FP_MUL_ARB_EXC_CNT_EN to enable the saturating exception counter.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_mul_arbiter_if.slave  bus
);

  arb_state_e            state_r;
  logic [ID_W-1:0]       rr_ptr_r;
  logic [DATA_WIDTH-1:0] op_a_r;
  logic [DATA_WIDTH-1:0] op_b_r;
  logic [ID_W-1:0]       id_r;
  logic                  rsp_valid_r;
  logic [ID_W-1:0]       rsp_id_r;
  logic [DATA_WIDTH-1:0] rsp_m_r;
  logic                  rsp_ovf_r;
  logic                  rsp_unf_r;

  logic [NUM_REQ-1:0]    grant_oh_s;
  logic [ID_W-1:0]       grant_idx_s;
  logic                  any_valid_s;
  logic                  take_s;
  logic                  grant_fire_s;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic [ID_W-1:0]       rr_next_s;
  logic [DATA_WIDTH-1:0] sel_a_s;
  logic [DATA_WIDTH-1:0] sel_b_s;
  logic [DATA_WIDTH-1:0] mul_m_s;
  logic                  mul_ovf_s;
  logic                  mul_unf_s;

  fp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_oh_s),
    .grant_idx (grant_idx_s),
    .any_valid (any_valid_s)
  );

  mul_main u_mul (
    .a         (op_a_r),
    .b         (op_b_r),
    .m         (mul_m_s),
    .overflow  (mul_ovf_s),
    .underflow (mul_unf_s)
  );

  // Grant is only offered when idle or while the current response is being consumed.
  always_comb begin
    take_s       = 1'b0;
    req_ready_s  = '0;
    rr_next_s    = '0;
    sel_a_s      = '0;
    sel_b_s      = '0;
    if (!rst_n) begin
      take_s = 1'b0;
    end else if (state_r == IDLE) begin
      take_s = 1'b1;
    end else if ((state_r == RESP) && bus.rsp_ready) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
    grant_fire_s = take_s && any_valid_s;
    if (grant_fire_s) begin
      req_ready_s = grant_oh_s;
    end else begin
      req_ready_s = '0;
    end
    if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_idx_s + ID_W'(1);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh_s[i]) begin
        sel_a_s = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b_s = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_a_s = sel_a_s;
        sel_b_s = sel_b_s;
      end
    end
  end

  // Control FSM with operand latch and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      id_r        <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_m_r     <= '0;
      rsp_ovf_r   <= 1'b0;
      rsp_unf_r   <= 1'b0;
    end else begin
      if (grant_fire_s) begin
        op_a_r   <= sel_a_s;
        op_b_r   <= sel_b_s;
        id_r     <= grant_idx_s;
        rr_ptr_r <= rr_next_s;
      end
      case (state_r)
        IDLE: begin
          if (grant_fire_s) begin
            state_r <= CALC;
          end
        end
        CALC: begin
          rsp_m_r     <= mul_m_s;
          rsp_ovf_r   <= mul_ovf_s;
          rsp_unf_r   <= mul_unf_s;
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= grant_fire_s ? CALC : IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

`ifdef FP_MUL_ARB_EXC_CNT_EN
  logic [EXC_CNT_W-1:0] exc_cnt_r;

  // Saturating count of results registered with an exception flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_cnt_r <= '0;
    end else if ((state_r == CALC) && (mul_ovf_s || mul_unf_s) && (exc_cnt_r != {EXC_CNT_W{1'b1}})) begin
      exc_cnt_r <= exc_cnt_r + EXC_CNT_W'(1);
    end else begin
      exc_cnt_r <= exc_cnt_r;
    end
  end

  assign bus.exc_count = exc_cnt_r;
`else
  assign bus.exc_count = '0;
`endif

  assign bus.req_ready     = req_ready_s;
  assign bus.rsp_valid     = rsp_valid_r;
  assign bus.rsp_id        = rsp_id_r;
  assign bus.rsp_m         = rsp_m_r;
  assign bus.rsp_overflow  = rsp_ovf_r;
  assign bus.rsp_underflow = rsp_unf_r;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: transaction-level scoreboard plus directed scenarios.
module tb_fp_mul_arbiter;
  import fp_mul_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fp_mul_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference IEEE single product (round to nearest even, flush zero/denormal, saturate).
  function automatic logic [33:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p, sig, rem, half;
    int e, sh;
    logic s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b00, s, 31'd0};
    p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p >= 64'h8000_0000_0000) begin sh = 24; e++; end else sh = 23;
    sig  = p >> sh;
    rem  = p - (sig << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && sig[0])) sig++;
    if (sig >= 64'h100_0000) begin sig = sig >> 1; e++; end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0) return {2'b01, s, 31'd0};
    return {2'b00, s, 8'(e), 23'(sig)};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0: e = 8'd0;
      1: e = 8'($urandom_range(200, 254));
      2: e = 8'($urandom_range(1, 50));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  typedef struct {
    logic [IW-1:0] id;
    logic [31:0]   m;
    logic          ovf;
    logic          unf;
    int            due;
  } item_t;

  item_t       q[$];
  item_t       last;
  int          cyc = 0;
  int          m_ptr = 0;
  logic [15:0] m_exc;

  // Scoreboard: one outstanding operation at most, result due two cycles after its grant.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic [33:0]  r;
    bit present, accept;
    int g, c;
    if (rst_n !== 1'b1) begin
      q.delete();
      m_ptr = 0;
      m_exc = 16'd0;
      last.id = '0; last.m = 32'd0; last.ovf = 1'b0; last.unf = 1'b0; last.due = 0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        last = q[0];
`ifdef FP_MUL_ARB_EXC_CNT_EN
        if ((last.ovf || last.unf) && m_exc != 16'hFFFF) m_exc = m_exc + 16'd1;
`endif
      end
      present = (q.size() > 0) && (q[0].due <= cyc);
      accept  = (q.size() == 0) || (present && bus.rsp_ready);
      exp_rdy = '0;
      g = -1;
      if (accept) begin
        for (int i = 0; i < N; i++) begin
          c = (m_ptr + i) % N;
          if (g < 0 && bus.req_valid[c]) g = c;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(present));
      chk("rsp_id", 64'(bus.rsp_id), 64'(last.id));
      chk("rsp_m", 64'(bus.rsp_m), 64'(last.m));
      chk("rsp_overflow", 64'(bus.rsp_overflow), 64'(last.ovf));
      chk("rsp_underflow", 64'(bus.rsp_underflow), 64'(last.unf));
      chk("exc_count", 64'(bus.exc_count), 64'(m_exc));
      if (present && bus.rsp_ready) void'(q.pop_front());
      if (g >= 0) begin
        item_t it;
        r = model_mul(bus.req_a[g*DW +: DW], bus.req_b[g*DW +: DW]);
        it.id = IW'(g); it.m = r[31:0]; it.ovf = r[33]; it.unf = r[32]; it.due = cyc + 2;
        q.push_back(it);
        m_ptr = (g + 1) % N;
      end
    end
    cyc++;
  end

  task automatic wait_grant(input int idx, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.req_ready[idx];
    end
    chk({nm, "_grant"}, 64'(seen), 64'd1);
  endtask

  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] em, input logic eo, input logic eu, input string nm);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b1;
    bus.req_a[idx*DW +: DW] = a;
    bus.req_b[idx*DW +: DW] = b;
    wait_grant(idx, nm);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({nm, "_id"}, 64'(bus.rsp_id), 64'(idx));
    chk({nm, "_m"}, 64'(bus.rsp_m), 64'(em));
    chk({nm, "_ovf"}, 64'(bus.rsp_overflow), 64'(eo));
    chk({nm, "_unf"}, 64'(bus.rsp_underflow), 64'(eu));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid[5];
    int gcyc[5];
    int ng;
    bit seen;

    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_m", 64'(bus.rsp_m), 64'd0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_exc", 64'(bus.exc_count), 64'd0);

    do_op(0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, "basic");
    do_op(2, 32'h3C2F_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, "zero");

    // Round robin: every requester holds valid from reset.
    @(posedge clk); #1 rst_n = 1'b0;
    bus.req_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*DW +: DW] = rand_fp();
      bus.req_b[i*DW +: DW] = rand_fp();
    end
    @(posedge clk); #1 rst_n = 1'b1;
    ng = 0;
    for (int k = 0; k < 30 && ng < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i] && ng < 5) begin
          gid[ng] = i; gcyc[ng] = k; ng++;
        end
      end
    end
    @(posedge clk); #1 bus.req_valid = '0;
    chk("rr_count", 64'(ng), 64'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 64'(gid[i]), 64'(i % N));
    for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd2);
    repeat (4) @(negedge clk);

    // Backpressure: hold the response for five cycles with another request waiting.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid[3] = 1'b1;
    bus.req_a[3*DW +: DW] = 32'h3FC0_0000;
    bus.req_b[3*DW +: DW] = 32'h4000_0000;
    wait_grant(3, "bp");
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    bus.req_valid[1] = 1'b1;
    bus.req_a[1*DW +: DW] = 32'h3F80_0000;
    bus.req_b[1*DW +: DW] = 32'h3F80_0000;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    chk("bp_rsp_rise", 64'(seen), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_hold_m", 64'(bus.rsp_m), 64'h4040_0000);
      chk("bp_hold_id", 64'(bus.rsp_id), 64'd3);
      chk("bp_hold_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_grant", 64'(bus.req_ready), 64'b0010);
    @(posedge clk); #1 bus.req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Exceptions, counted from a clean reset.
    pulse_reset();
    do_op(1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0, "ovf");
    do_op(3, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1, "unf");
`ifdef FP_MUL_ARB_EXC_CNT_EN
    chk("exc_total", 64'(bus.exc_count), 64'd2);
`else
    chk("exc_total", 64'(bus.exc_count), 64'd0);
`endif

    // Reset while a req1 operation is in CALC.
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b1;
    bus.req_a[1*DW +: DW] = 32'h4000_0000;
    bus.req_b[1*DW +: DW] = 32'h4000_0000;
    wait_grant(1, "mid");
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("mid_rsp_m", 64'(bus.rsp_m), 64'd0);
    chk("mid_flags", 64'({bus.rsp_overflow, bus.rsp_underflow}), 64'd0);
    chk("mid_exc", 64'(bus.exc_count), 64'd0);
    chk("mid_req_ready", 64'(bus.req_ready), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_pulse", 64'(bus.rsp_valid), 64'd0);
    end
    @(posedge clk); #1 bus.req_valid = 4'b1001;
    @(negedge clk);
    chk("mid_ptr_zero", 64'(bus.req_ready), 64'b0001);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    wait_grant(3, "mid_drain");
    @(posedge clk); #1 bus.req_valid[3] = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized traffic against the scoreboard.
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) bus.req_valid[i] = ~bus.req_valid[i];
        if ($urandom_range(0, 1) == 0) begin
          bus.req_a[i*DW +: DW] = rand_fp();
          bus.req_b[i*DW +: DW] = rand_fp();
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Shares one combinational single-precision multiplier (`mul_main`) among NUM_REQ requesters. The arbitration policy is round-robin. Each requester side uses a valid/ready handshake, and a single registered response port returns the product, the flags and the winning requester ID. The block sits between the floating-point clients and the multiplier datapath and is the only driver of the multiplier's `a`/`b` inputs.

## Interface
- DATA_WIDTH, 32, operand/result width (IEEE-754 single).
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), requester ID width (derived).

One clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  per-requester accept (at most one bit set).
- req_a  in  NUM_REQ*DATA_WIDTH  operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  operand B, same packing.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  requester that owns the result.
- rsp_m  out  DATA_WIDTH  product.
- rsp_overflow  out  1  multiplier overflow flag.
- rsp_underflow  out  1  multiplier underflow flag.
- exc_count  out  16  saturating exception counter (see Configuration).

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - If any req_valid is set, grant the first valid requester at or after rr_ptr (cyclic search).
  - req_ready[g]=1 combinationally in the same cycle.
  - Latch op_a=req_a[g], op_b=req_b[g] and id=g; set rr_ptr=(g+1)%NUM_REQ; go to CALC.
- **CALC**
  - `mul_main` sees the latched operands only.
  - At the clock edge, register m/overflow/underflow into the rsp_* registers, set rsp_valid=1 and go to RESP.
- **RESP**
  - rsp_* outputs hold stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1:
    - If any req_valid is set, grant exactly as in IDLE in the same cycle and go to CALC.
    - Otherwise go to IDLE.
  - rsp_valid drops in the next cycle unless re-asserted by the following CALC.
- req_ready is 0 in CALC, and in RESP while rsp_ready=0.
- A requester may drop req_valid before it is granted; it is then simply skipped.
- A requester holding req_valid with changing operands gets whatever value was present in its grant cycle.
- NUM_REQ wrap: rr_ptr goes from NUM_REQ-1 to 0.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, req_ready=0.
  - rsp_valid=0, rsp_id=0, rsp_m=0, rsp_overflow=0, rsp_underflow=0, exc_count=0.
- Latency: grant in cycle T, rsp_valid=1 in cycle T+2.
- Throughput: one operation per 2 cycles with rsp_ready held at 1.
- Reset mid-operation (rst_n=0 in CALC or RESP):
  - At the next edge, return to reset values.
  - The in-flight result is discarded and never presented.
- Simultaneous requests and the response handshake in the same RESP cycle: legal, and served back-to-back as described in Operation.

## Configuration
- FP_MUL_ARB_EXC_CNT_EN **defined**:
  - exc_count increments by 1 in each cycle where a result is registered (CALC to RESP) with rsp_overflow or rsp_underflow set.
  - It saturates at 16'hFFFF.
- FP_MUL_ARB_EXC_CNT_EN **undefined**:
  - The counter logic is absent.
  - exc_count is tied to 0 and the port remains present.

## Structure
- Shared package fp_mul_pkg holds:
  - The state enum type (IDLE/CALC/RESP).
  - The DATA_WIDTH default constant.
  - The exc_count width constant (16).
- One sub-module, fp_rr_arbiter, is natural:
  - Purely combinational.
  - Inputs: req vector and rr_ptr. Outputs: one-hot grant, grant index, any-valid.
- `mul_main` is instantiated unchanged, once.

## Test plan
- **Basic product:** req0 with a=0x40000000 (2.0), b=0x40400000 (3.0), rsp_ready=1.
  - req_ready[0] high in grant cycle T.
  - At T+2: rsp_valid=1, rsp_id=0, rsp_m=0x40C00000, both flags 0.
- **Zero operand:** req2 with a=0x3C2F0000, b=0x00000000.
  - rsp_m=0x00000000, rsp_id=2, no flags.
- **Round-robin:** all four req_valid held high from reset with rsp_ready=1.
  - Grant order is 0,1,2,3,0.
  - Each grant is spaced 2 cycles apart, and no requester is granted twice before the others.
- **Backpressure:** rsp_ready=0 for 5 cycles after rsp_valid rises.
  - rsp_m/rsp_id stay stable and req_ready stays 0.
  - The next grant occurs in the cycle rsp_ready rises.
- **Exceptions:**
  - 0x7F000000 × 0x7F000000 gives rsp_overflow=1.
  - 0x00800000 × 0x00800000 gives rsp_underflow=1.
  - With FP_MUL_ARB_EXC_CNT_EN, exc_count=2 afterwards; without it, exc_count=0.
- **Reset mid-operation:** rst_n=0 during CALC of a req1 operation.
  - At the next edge, all outputs are at reset values and no rsp_valid pulse appears.
  - The next request after reset is granted from rr_ptr=0.
